// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift_sequencer slice: state encoding, data width
// and the per-cycle step limit imposed by the 3-bit BarrelShifter.
package shift_sequencer_pkg;

    localparam int DATA_W   = 8;
    localparam int STEP_W   = 3;
    localparam int STEP_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer; slave is the sequencer,
// master is the request source plus result consumer.
interface shift_sequencer_if #(
    parameter int AMT_W = 5
);
    import shift_sequencer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_shamt;
    logic              in_dir;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_shamt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_sequencer_barrel.sv
// Single-cycle 8-bit logical barrel shifter (zero fill), shift range 0..7.
module BarrelShifter (
    input  logic [7:0] in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] out
);

    // dir=1 shifts left, dir=0 shifts right
    always_comb begin
        if (dir) out = in << shamt;
        else     out = in >> shamt;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle wide-amount shifter built on the 3-bit BarrelShifter.
// Optional macro SHIFT_SEQ_ZERO_SKIP_EN: amounts >= 8 finish in one SHIFT cycle.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_sequencer_if.slave     bus,
    output logic                 busy
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;

    logic [STEP_W-1:0] step;
    logic [AMT_W-1:0]  rem_next;
    logic              rem_big;
    logic [DATA_W-1:0] shift_out;

    // Step never exceeds rem, so rem_next cannot wrap
    assign rem_big  = (rem_q > AMT_W'(STEP_MAX));
    assign step     = rem_big ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];
    assign rem_next = rem_q - AMT_W'(step);

    BarrelShifter u_shifter (
        .in    (work_q),
        .shamt (step),
        .dir   (dir_q),
        .out   (shift_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    rem_d   = bus.in_shamt;
                    dir_d   = bus.in_dir;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
                // Any amount of 8 or more clears the byte, so skip the iterations
                if (rem_big) begin
                    work_d  = '0;
                    rem_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    work_d = shift_out;
                    rem_d  = rem_next;
                    if (rem_next == '0) state_d = ST_DONE;
                end
`else
                work_d = shift_out;
                rem_d  = rem_next;
                if (rem_next == '0) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.out_data = work_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, shifts, latency, backpressure, mid-op reset.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    shift_sequencer_if #(.AMT_W(5)) bus ();

    shift_sequencer #(.AMT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, check latency and data, then drain it
    task automatic do_req(input string tag, input logic [7:0] d, input logic [4:0] amt,
                          input logic dir, input logic [7:0] exp_d, input int exp_k);
        int n;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = amt;
        bus.in_dir   = dir;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_k"}, 32'(n), 32'(exp_k));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int k20, k14;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
        k20 = 1;
        k14 = 1;
`else
        k20 = 3;
        k14 = 2;
`endif
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_shamt  = 5'd0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);

        do_req("l3",  8'h66, 5'd3,  1'b1, 8'h30, 1);
        do_req("r20", 8'hFF, 5'd20, 1'b0, 8'h00, k20);
        do_req("l0",  8'h81, 5'd0,  1'b1, 8'h81, 1);
        do_req("r7",  8'h81, 5'd7,  1'b0, 8'h01, 1);
        do_req("r31", 8'h80, 5'd31, 1'b0, 8'h00, (k20 == 1) ? 1 : 5);
        do_req("l14_walk", 8'h21, 5'd14, 1'b1, 8'h00, k14);
        do_req("r9",  8'hF0, 5'd9,  1'b0, 8'h00, (k20 == 1) ? 1 : 2);

        // Backpressure: result held, in_ready low, stray request ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0F;
        bus.in_shamt = 5'd2;
        bus.in_dir   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'hAA;
                bus.in_shamt = 5'd1;
                bus.in_dir   = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            chk("bp_data", 32'(bus.out_data), 32'h3C);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data_end", 32'(bus.out_data), 32'h3C);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_after_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("bp_no_queue", 32'(busy), 32'd0);

        // out_ready high in advance: transfer happens on the first DONE edge
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h03;
        bus.in_shamt  = 5'd5;
        bus.in_dir    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("early_rdy_valid", 32'(bus.out_valid), 32'd1);
        chk("early_rdy_data", 32'(bus.out_data), 32'h60);
        tick();
        chk("early_rdy_idle", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        // Reset in the second SHIFT cycle abandons the operation
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        bus.in_shamt = 5'd31;
        bus.in_dir   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_out_data", 32'(bus.out_data), 32'h00);
        chk("mid_busy_low", 32'(busy), 32'd0);
        do_req("post_rst", 8'h01, 5'd1, 1'b1, 8'h02, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle front end for the 8-bit `BarrelShifter`. It accepts a logical shift request whose amount can exceed the shifter's 3-bit range (0..31). It then drives `BarrelShifter` iteratively, applying at most 7 positions per cycle, and returns the result over a valid/ready handshake. It sits between the operand/request source and the result consumer, and makes the single-cycle shifter usable for wide shift amounts.

## Interface
- `AMT_W`, default 5: width of the requested shift amount (max amount 2^AMT_W−1).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: block can accept a request.
- `in_data` input 8: operand.
- `in_shamt` input AMT_W: total shift amount.
- `in_dir` input 1: 1 = left, 0 = right (logical, zero fill).
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 8: shifted result.
- `busy` output 1: high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `work`←`in_data`, `rem`←`in_shamt`, `dir`←`in_dir`; go to SHIFT.
- **SHIFT**
  - `step` = min(`rem`, 7); drives `BarrelShifter` with (`work`, `step`, `dir`).
  - Each cycle: `work`←shifter output, `rem`←`rem`−`step`.
  - Go to DONE when `rem`−`step`==0.
  - Amount 0 still spends exactly one SHIFT cycle, with `step`=0.
- **DONE**
  - `out_valid`=1; `out_data`=`work`, held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is 0 outside IDLE. `in_valid` is ignored in SHIFT and DONE; no request is lost or queued.
- Arithmetic:
  - `rem` is AMT_W bits and never underflows, because `step` ≤ `rem`.
  - `step` is 3 bits.
  - Result equals `in_data` shifted by `in_shamt` with zero fill. Any amount ≥8 yields 0x00.
- `out_data` is registered (= `work`) and is meaningful only while `out_valid`=1.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0x00, `rem`=0.
- Request accepted at edge E0. SHIFT occupies k = max(1, ⌈amt/7⌉) cycles. `out_valid` rises after edge E0+k.
  - Examples: amt 0..7 → k=1; amt 31 → k=5 (steps 7,7,7,7,3).
- Result transfers on the first edge with `out_valid`&&`out_ready`. `in_ready`=1 in the following cycle.
- Minimum request-to-request spacing: k+2 cycles. There is no back-to-back acceptance.
- `rst` asserted in any state: the operation is abandoned, and all outputs take their reset values after that edge. `rst` has priority over any handshake on the same edge.
- `out_ready` held high before DONE has no effect; the transfer occurs on the first DONE cycle.

## Configuration
- `SHIFT_SEQ_ZERO_SKIP_EN`
  - **Defined:** when latched `rem` ≥ 8, SHIFT lasts exactly one cycle and loads `work`←0x00 directly. Latency k=1 for all amounts.
  - **Undefined:** pure iterative behaviour as above.
  - Results are identical either way; only latency differs.

## Structure
- Shared package/header holds:
  - State encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - `STEP_MAX`=7.
  - Data width 8.
- One sub-module, instantiated rather than duplicated: the existing `BarrelShifter` (ports `in`, `shamt`, `dir`, `out`).
- Step selection and the `rem` update are inline combinational logic.

## Test plan
- After reset: check `in_ready`=1, `out_valid`=0, `out_data`=0x00. Then request 0x66, amt 3, left → 0x30 with `out_valid` one cycle after the SHIFT cycle (k=1).
- 0xFF, amt 20, right:
  - Macro undefined → 0x00 after 3 SHIFT cycles (steps 7,7,6).
  - Macro defined → 0x00 after 1 SHIFT cycle.
- 0x81, amt 0, left → 0x81 after 1 SHIFT cycle. Then 0x81, amt 7, right → 0x01.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out_data` stays stable and `in_ready`=0.
  - A new `in_valid` pulse is ignored.
  - Raising `out_ready` completes the transfer; `in_ready`=1 the next cycle.
- Reset mid-operation: 0x01, amt 31, left; assert `rst` in the 2nd SHIFT cycle.
  - Next cycle: IDLE, `out_valid`=0, `out_data`=0x00.
  - A following request 0x01, amt 1, left → 0x02.
